pc_fetch_unit: RTL and testbench

- Instruction-fetch and PC-sequencing block for the single-cycle CPU.
- Holds the PC and fetches one 32-bit instruction per step from instruction memory over a req/rvalid handshake.
- Presents the instruction to the control decoder and core datapath.
- On commit, applies the decoder's pcsrc and halt outputs to compute the next PC.

---
 rtl/pc_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencing and instruction fetch for the single-cycle CPU.
//
// Each instruction takes these steps: FETCH issues one read, WAIT holds until
// the memory returns the word, EXEC presents it until the core commits, and
// the next PC is then taken from the decoder's pcsrc. A halting commit parks
// the unit in HALT until reset.
//
// Handshake: o_imem_req is a one-cycle pulse with o_imem_addr valid in that
// cycle. The memory answers with i_imem_rvalid=1 in a later cycle (at least one
// cycle after the request, with no upper bound). rvalid is accepted only in
// WAIT. i_commit is accepted only in EXEC, which is the only state in which
// o_instr_valid=1.
//
// Optional feature: define PC_FETCH_RETIRE_CNT_EN to add o_retire_cnt, a
// wrapping count of accepted commits that includes the halting instruction.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_pcsrc,
  input  logic              i_halt_req,
  input  logic [15:0]       i_imm16,
  input  logic [25:0]       i_jaddr,
  input  logic              i_commit,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_rvalid,
  input  logic [31:0]       i_imem_rdata,
  output logic [31:0]       o_instr_out,
  output logic              o_instr_valid,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_halted,
  output logic [1:0]        o_state
`ifdef PC_FETCH_RETIRE_CNT_EN
  ,
  output logic [31:0]       o_retire_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Word-aligned reset PC and the mask for the jump's 28-bit region.
  localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_PC) & ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [31:0]       r_instr;
  logic [31:0]       w_instr_nxt;
  logic              r_instr_valid;
  logic              w_valid_nxt;
  logic              r_halted;
  logic              w_halted_nxt;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_jmp_tgt;
  logic              w_accept;

  // Candidate next PCs; all arithmetic wraps modulo 2^ADDR_W.
  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  assign w_br_off   = {{(ADDR_W-18){i_imm16[15]}}, i_imm16, 2'b00};
  assign w_br_tgt   = w_pc_plus4 + w_br_off;
  assign w_jmp_tgt  = (w_pc_plus4 & ~LOW28_MASK) | ADDR_W'({i_jaddr, 2'b00});
  assign w_accept   = (r_state == S_EXEC) && i_commit;

  assign o_instr_out   = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_pc_out      = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_halted      = r_halted;
  assign o_state       = r_state;

  // Next-state, next-PC and memory request decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_instr_valid;
    w_halted_nxt = r_halted;
    o_imem_req  = 1'b0;
    o_imem_addr = '0;
    case (r_state)
      S_FETCH: begin
        o_imem_req  = 1'b1;
        o_imem_addr = r_pc;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          w_instr_nxt = i_imem_rdata;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_commit) begin
          w_valid_nxt = 1'b0;
          if (i_halt_req) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end else begin
            case (i_pcsrc)
              2'd1:    w_pc_nxt = w_br_tgt;
              2'd2:    w_pc_nxt = w_jmp_tgt;
              default: w_pc_nxt = w_pc_plus4;
            endcase
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b1;
      end
    endcase
    // No request leaves the block while reset is held.
    if (i_rst) begin
      o_imem_req  = 1'b0;
      o_imem_addr = '0;
    end
  end

  // State, PC and instruction registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RST_PC;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_valid_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

`ifdef PC_FETCH_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Count accepted commits; nothing is accepted in HALT so the count freezes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_retire_cnt <= 32'h0;
    end else if (w_accept) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign o_retire_cnt = r_retire_cnt;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: three instances (reset PCs 0, 0xFFFF_FFFC and
// 0x1000_0040) share one stimulus stream. A transaction-level model tracks the
// architectural PC of each, and a negedge compare process checks every output.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  pcsrc;
  logic        halt_req;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        commit;
  logic        rvalid;
  logic [31:0] rdata;

  logic [2:0]  req;
  logic [31:0] addr  [3];
  logic [31:0] instr [3];
  logic [2:0]  valid;
  logic [31:0] pc    [3];
  logic [31:0] pcp4  [3];
  logic [2:0]  halted;
  logic [1:0]  st    [3];
`ifdef PC_FETCH_RETIRE_CNT_EN
  logic [31:0] rc    [3];
`endif

  // model / expectations
  logic [31:0] rpc   [3];
  logic [31:0] m_pc  [3];
  logic [31:0] p_pc  [3];
  logic [31:0] m_retire;
  logic        pend, pend_halt;
  logic        e_req, e_valid, e_halted, e_instr_chk;
  logic [31:0] e_instr;
  logic        chk_en;
  int          n_total, n_bad;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) u0 (
    .i_clk(clk), .i_rst(rst), .i_pcsrc(pcsrc), .i_halt_req(halt_req),
    .i_imm16(imm16), .i_jaddr(jaddr), .i_commit(commit),
    .o_imem_req(req[0]), .o_imem_addr(addr[0]), .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata), .o_instr_out(instr[0]), .o_instr_valid(valid[0]),
    .o_pc_out(pc[0]), .o_pc_plus4(pcp4[0]), .o_halted(halted[0]), .o_state(st[0])
`ifdef PC_FETCH_RETIRE_CNT_EN
    , .o_retire_cnt(rc[0])
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(32)) u1 (
    .i_clk(clk), .i_rst(rst), .i_pcsrc(pcsrc), .i_halt_req(halt_req),
    .i_imm16(imm16), .i_jaddr(jaddr), .i_commit(commit),
    .o_imem_req(req[1]), .o_imem_addr(addr[1]), .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata), .o_instr_out(instr[1]), .o_instr_valid(valid[1]),
    .o_pc_out(pc[1]), .o_pc_plus4(pcp4[1]), .o_halted(halted[1]), .o_state(st[1])
`ifdef PC_FETCH_RETIRE_CNT_EN
    , .o_retire_cnt(rc[1])
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'h1000_0042), .ADDR_W(32)) u2 (
    .i_clk(clk), .i_rst(rst), .i_pcsrc(pcsrc), .i_halt_req(halt_req),
    .i_imm16(imm16), .i_jaddr(jaddr), .i_commit(commit),
    .o_imem_req(req[2]), .o_imem_addr(addr[2]), .i_imem_rvalid(rvalid),
    .i_imem_rdata(rdata), .o_instr_out(instr[2]), .o_instr_valid(valid[2]),
    .o_pc_out(pc[2]), .o_pc_plus4(pcp4[2]), .o_halted(halted[2]), .o_state(st[2])
`ifdef PC_FETCH_RETIRE_CNT_EN
    , .o_retire_cnt(rc[2])
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Architectural next-PC rule, written from the ISA description.
  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [1:0] src,
                                          input logic [15:0] imm, input logic [25:0] ja);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(imm)) * 4;
    if (src == 2'd1) return seq + 32'(off);
    if (src == 2'd2) return (seq & 32'hF000_0000) | (32'(ja) * 32'd4);
    return seq;
  endfunction

  // Advance one cycle; a commit made last cycle takes effect on this edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (pend) begin
      m_retire = m_retire + 32'd1;
      if (pend_halt) e_halted = 1'b1;
      else for (int k = 0; k < 3; k++) m_pc[k] = p_pc[k];
      pend = 1'b0;
    end
  endtask

  task automatic junk();
    commit   = 1'($urandom_range(0, 1));
    halt_req = 1'($urandom_range(0, 1));
    pcsrc    = 2'($urandom_range(0, 3));
    imm16    = 16'($urandom());
    jaddr    = 26'($urandom());
    rvalid   = 1'($urandom_range(0, 1));
    rdata    = $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    junk();
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) m_pc[k] = rpc[k];
      m_retire = 32'h0; pend = 1'b0;
      e_req = 1'b0; e_valid = 1'b0; e_halted = 1'b0;
      e_instr_chk = 1'b1; e_instr = 32'h0;
      junk();
    end
  endtask

  task automatic run_instr(input int lat, input int hold, input logic [1:0] src,
                           input logic [15:0] imm, input logic [25:0] ja,
                           input logic hlt, input logic abort);
    logic [31:0] data;
    data = $urandom();
    // request cycle (stale rvalid / stray commit here must be ignored)
    cyc();
    rst = 1'b0;
    junk();
    e_req = 1'b1; e_valid = 1'b0; e_instr_chk = 1'b0;
    // memory latency
    for (int i = 1; i <= lat; i++) begin
      cyc();
      junk();
      e_req = 1'b0;
      rvalid = (i == lat);
      rdata  = (i == lat) ? data : $urandom();
      if (abort) begin
        rst = 1'b1;
        return;
      end
    end
    // instruction presented until commit
    for (int h = 0; h <= hold; h++) begin
      cyc();
      junk();
      e_valid = 1'b1; e_instr = data;
      commit = (h == hold);
      if (h == hold) begin
        pcsrc = src; imm16 = imm; jaddr = ja; halt_req = hlt;
        for (int k = 0; k < 3; k++) p_pc[k] = hlt ? m_pc[k] : next_pc(m_pc[k], src, imm, ja);
        pend = 1'b1; pend_halt = hlt;
      end
    end
  endtask

  task automatic halt_hold(input int n);
    for (int c = 0; c < n; c++) begin
      cyc();
      junk();
      e_req = 1'b0; e_valid = 1'b0; e_halted = 1'b1;
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("req%0d", k), 32'(req[k]), 32'(e_req));
        chk($sformatf("addr%0d", k), addr[k], e_req ? m_pc[k] : 32'h0);
        chk($sformatf("valid%0d", k), 32'(valid[k]), 32'(e_valid));
        chk($sformatf("halted%0d", k), 32'(halted[k]), 32'(e_halted));
        chk($sformatf("pc%0d", k), pc[k], m_pc[k]);
        chk($sformatf("pcp4_%0d", k), pcp4[k], m_pc[k] + 32'd4);
        if (e_valid || e_instr_chk) chk($sformatf("instr%0d", k), instr[k], e_instr);
`ifdef PC_FETCH_RETIRE_CNT_EN
        chk($sformatf("retire%0d", k), rc[k], m_retire);
`endif
      end
    end
  end

  initial begin
    int lat, hold;
    logic hlt, abrt;
    n_total = 0; n_bad = 0; chk_en = 1'b0; pend = 1'b0; pend_halt = 1'b0;
    rpc[0] = 32'h0000_0000; rpc[1] = 32'hFFFF_FFFC; rpc[2] = 32'h1000_0040;
    rst = 1'b1; m_retire = 32'h0;
    junk();
    do_reset();

    // three sequential instructions, 1-cycle memory
    run_instr(1, 0, 2'd0, 16'h0, 26'h0, 1'b0, 1'b0);
    chk("lit_seq0", p_pc[0], 32'h0000_0004);
    chk("lit_wrap", p_pc[1], 32'h0000_0000);
    run_instr(1, 0, 2'd0, 16'h0, 26'h0, 1'b0, 1'b0);
    run_instr(1, 0, 2'd3, 16'h0, 26'h0, 1'b0, 1'b0);
    chk("lit_seq2", p_pc[0], 32'h0000_000C);
    run_instr(1, 0, 2'd0, 16'h0, 26'h0, 1'b0, 1'b0);
    // branches from 0x10
    run_instr(1, 0, 2'd1, 16'hFFFF, 26'h0, 1'b0, 1'b0);
    chk("lit_br_back", p_pc[0], 32'h0000_0010);
    run_instr(1, 1, 2'd1, 16'h0003, 26'h0, 1'b0, 1'b0);
    chk("lit_br_fwd", p_pc[0], 32'h0000_0020);
    // long latency with stray commits while waiting
    run_instr(5, 2, 2'd0, 16'h0, 26'h0, 1'b0, 1'b0);
    chk("lit_lat5", p_pc[0], 32'h0000_0024);

    // jump from 0x1000_0040, then halt
    do_reset();
    run_instr(1, 0, 2'd2, 16'h0, 26'h0000100, 1'b0, 1'b0);
    chk("lit_jump", p_pc[2], 32'h1000_0400);
    chk("lit_jump0", p_pc[0], 32'h0000_0400);
    run_instr(2, 0, 2'd1, 16'h0040, 26'h0, 1'b1, 1'b0);
    halt_hold(20);
    chk("lit_retire", m_retire, 32'd2);
    do_reset();

    // randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      lat  = $urandom_range(1, 6);
      hold = $urandom_range(0, 3);
      hlt  = ($urandom_range(0, 19) == 0);
      abrt = !hlt && ($urandom_range(0, 24) == 0);
      run_instr(lat, hold, 2'($urandom_range(0, 3)), 16'($urandom()), 26'($urandom()), hlt, abrt);
      if (abrt) begin
        do_reset();
      end else if (hlt) begin
        halt_hold($urandom_range(3, 8));
        do_reset();
      end
    end
    cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
